// File: rtl/vdc_pwm.sv
// Heater PWM: fixed-period counter, strobed duty word clamped and min-pulse limited, applied at wrap.
// Latency: a strobe takes effect at the next wrap (worst case PERIOD cycles); out/upd/period_start registered.
// Backpressure: none; nh_stb is always accepted and the latest pending value wins.
module vdc_pwm #(
  parameter int FILTER_IO_SIZE = 18,
  parameter int PERIOD         = 100000,
  parameter int CNT_W          = 17,
  parameter int MIN_PW         = 50
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             on,
  input  logic                             nh_stb,
  input  logic signed [FILTER_IO_SIZE-1:0] nh_in,
  output logic                             out,
  output logic                             period_start,
  output logic                             upd,
  output logic        [CNT_W-1:0]          duty
);

  logic        [CNT_W-1:0]          cnt_q, cnt_d;
  logic        [CNT_W-1:0]          duty_q, duty_d;
  logic signed [FILTER_IO_SIZE-1:0] pend_val_q, pend_val_d;
  logic                             pend_q, pend_d;
  logic                             armed_q, armed_d;
  logic                             out_q, out_d;
  logic                             upd_q, upd_d;
  logic                             pstart_q, pstart_d;
  logic                             wrap;
  logic                             load;
  logic signed [FILTER_IO_SIZE-1:0] sel_val;

  // Clamp to [0, PERIOD], then snap pulses shorter than MIN_PW (high or low) to the rail.
  function automatic logic [CNT_W-1:0] eff_duty(input logic signed [FILTER_IO_SIZE-1:0] v);
    int d;
    d = int'(v);
    if (d < 0) begin
      d = 0;
    end else if (d > PERIOD) begin
      d = PERIOD;
    end
    if (d > 0 && d < MIN_PW) begin
      d = 0;
    end else if (d > PERIOD - MIN_PW && d < PERIOD) begin
      d = PERIOD;
    end
    return CNT_W'(d);
  endfunction

  always_comb begin
    wrap       = (cnt_q == CNT_W'(PERIOD - 1));
    cnt_d      = wrap ? '0 : cnt_q + CNT_W'(1);

    // A strobe landing on the last cycle of the period is loaded at this very wrap.
    sel_val    = nh_stb ? nh_in : pend_val_q;
    load       = wrap && (pend_q || nh_stb);

    pend_val_d = nh_stb ? nh_in : pend_val_q;
    pend_d     = pend_q;
    if (load) begin
      pend_d = 1'b0;
    end else if (nh_stb) begin
      pend_d = 1'b1;
    end

    duty_d   = load ? eff_duty(sel_val) : duty_q;
    upd_d    = load;
    pstart_d = (cnt_d == '0);

    // Arming only at a wrap avoids a truncated first pulse after enable.
    armed_d  = on && (armed_q || wrap);
    out_d    = armed_d && (cnt_d < duty_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      duty_q     <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      armed_q    <= 1'b0;
      out_q      <= 1'b0;
      upd_q      <= 1'b0;
      pstart_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      armed_q    <= armed_d;
      out_q      <= out_d;
      upd_q      <= upd_d;
      pstart_q   <= pstart_d;
    end
  end

  assign out          = out_q;
  assign period_start = pstart_q;
  assign upd          = upd_q;
  assign duty         = duty_q;

endmodule
